mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single byte-addressed memory.
// Each accepted request runs IDLE -> ACCESS -> RESP. Reads sample memory
// during ACCESS. Writes return the old contents. Misaligned or out-of-range
// accesses are flagged and never write memory.
module mem_arbiter #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MEM_BYTES  = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  m0_req_i,
   input  logic [1:0]            m0_we_i,
   input  logic [ADDR_WIDTH-1:0] m0_addr_i,
   input  logic [DATA_WIDTH-1:0] m0_wdata_i,
   output logic                  m0_gnt_o,
   output logic                  m0_rvalid_o,
   output logic [DATA_WIDTH-1:0] m0_rdata_o,
   output logic                  m0_err_o,
   input  logic                  m1_req_i,
   input  logic [1:0]            m1_we_i,
   input  logic [ADDR_WIDTH-1:0] m1_addr_i,
   input  logic [DATA_WIDTH-1:0] m1_wdata_i,
   output logic                  m1_gnt_o,
   output logic                  m1_rvalid_o,
   output logic [DATA_WIDTH-1:0] m1_rdata_o,
   output logic                  m1_err_o,
   output logic [1:0]            mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wd_o,
   input  logic [DATA_WIDTH-1:0] mem_rd_i
);

   localparam int unsigned AW1 = ADDR_WIDTH + 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic                  last_q, last_d;
   logic                  owner_q, owner_d;
   logic [1:0]            we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  err_q, err_d;
   logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
   logic                  rerr0_q, rerr0_d, rerr1_q, rerr1_d;
   logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

   logic                  sel;
   logic [1:0]            sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic [AW1-1:0]        sel_nbytes;
   logic [AW1-1:0]        sel_end;
   logic                  sel_err;

   // Pick the winner. On a tie, the master not served last wins. Then check alignment and bounds.
   always_comb begin
      sel        = 1'b0;
      sel_nbytes = AW1'(4);
      if (m0_req_i && m1_req_i) begin
         sel = ~last_q;
      end else begin
         sel = m1_req_i;
      end
      sel_we    = sel ? m1_we_i    : m0_we_i;
      sel_addr  = sel ? m1_addr_i  : m0_addr_i;
      sel_wdata = sel ? m1_wdata_i : m0_wdata_i;
      case (sel_we)
         2'b10:   sel_nbytes = AW1'(2);
         2'b11:   sel_nbytes = AW1'(1);
         default: sel_nbytes = AW1'(4);
      endcase
      // The extra top bit keeps addresses near the top of the space from wrapping back into range.
      sel_end = {1'b0, sel_addr} + sel_nbytes;
      sel_err = ((sel_we == 2'b01) && (sel_addr[1:0] != 2'b00))
              || ((sel_we == 2'b10) && sel_addr[0])
              || (sel_end > AW1'(MEM_BYTES));
   end

   // Next-state and registered response logic.
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      owner_d   = owner_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      err_d     = err_q;
      gnt0_d    = 1'b0;
      gnt1_d    = 1'b0;
      rvalid0_d = 1'b0;
      rvalid1_d = 1'b0;
      rerr0_d   = 1'b0;
      rerr1_d   = 1'b0;
      rdata0_d  = '0;
      rdata1_d  = '0;
      case (state_q)
         S_IDLE: begin
            if (m0_req_i || m1_req_i) begin
               state_d = S_ACCESS;
               owner_d = sel;
               last_d  = sel;
               we_d    = sel_we;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               err_d   = sel_err;
               gnt0_d  = ~sel;
               gnt1_d  = sel;
            end
         end
         S_ACCESS: begin
            state_d   = S_RESP;
            rvalid0_d = ~owner_q;
            rvalid1_d = owner_q;
            rerr0_d   = ~owner_q & err_q;
            rerr1_d   = owner_q & err_q;
            if (!err_q) begin
               rdata0_d = owner_q ? '0 : mem_rd_i;
               rdata1_d = owner_q ? mem_rd_i : '0;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Memory port is driven only during ACCESS. Writes are blocked on error or reset.
   always_comb begin
      mem_we_o   = 2'b00;
      mem_addr_o = '0;
      mem_wd_o   = '0;
      if (state_q == S_ACCESS) begin
         mem_addr_o = addr_q;
         mem_wd_o   = wdata_q;
         if (!err_q && !rst) begin
            mem_we_o = we_q;
         end
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         last_q    <= 1'b1;
         owner_q   <= 1'b0;
         we_q      <= 2'b00;
         addr_q    <= '0;
         wdata_q   <= '0;
         err_q     <= 1'b0;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rerr0_q   <= 1'b0;
         rerr1_q   <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         owner_q   <= owner_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         err_q     <= err_d;
         gnt0_q    <= gnt0_d;
         gnt1_q    <= gnt1_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
         rerr0_q   <= rerr0_d;
         rerr1_q   <= rerr1_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
      end
   end

   assign m0_gnt_o    = gnt0_q;
   assign m1_gnt_o    = gnt1_q;
   assign m0_rvalid_o = rvalid0_q;
   assign m1_rvalid_o = rvalid1_q;
   assign m0_err_o    = rerr0_q;
   assign m1_err_o    = rerr1_q;
   assign m0_rdata_o  = rdata0_q;
   assign m1_rdata_o  = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned MB = 256;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_req_i, m1_req_i;
   logic [1:0]    m0_we_i, m1_we_i;
   logic [AW-1:0] m0_addr_i, m1_addr_i;
   logic [DW-1:0] m0_wdata_i, m1_wdata_i;
   logic          m0_gnt_o, m0_rvalid_o, m0_err_o;
   logic          m1_gnt_o, m1_rvalid_o, m1_err_o;
   logic [DW-1:0] m0_rdata_o, m1_rdata_o;
   logic [1:0]    mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wd_o;
   logic [DW-1:0] mem_rd_i;

   logic [7:0]    mem     [MB];
   logic [7:0]    ref_mem [MB];

   bit            pend [2];
   logic [1:0]    pwe  [2];
   logic [31:0]   pa   [2];
   logic [31:0]   pd   [2];
   int            ref_last;
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_BYTES(MB)) dut (
      .clk(clk), .rst(rst),
      .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
      .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
      .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
      .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
      .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i)
   );

   // Byte memory attached to the DUT: combinational read, clocked write.
   always_comb begin
      mem_rd_i = {mem[8'(mem_addr_o + 32'd3)], mem[8'(mem_addr_o + 32'd2)],
                  mem[8'(mem_addr_o + 32'd1)], mem[8'(mem_addr_o)]};
   end

   always @(posedge clk) begin
      case (mem_we_o)
         2'b01: for (int i = 0; i < 4; i++) mem[8'(mem_addr_o + 32'(i))] <= mem_wd_o[8*i +: 8];
         2'b10: for (int i = 0; i < 2; i++) mem[8'(mem_addr_o + 32'(i))] <= mem_wd_o[8*i +: 8];
         2'b11: mem[8'(mem_addr_o)] <= mem_wd_o[7:0];
         default: ;
      endcase
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int nbytes(input logic [1:0] we);
      return (we == 2'b10) ? 2 : (we == 2'b11) ? 1 : 4;
   endfunction

   function automatic bit model_err(input logic [1:0] we, input logic [31:0] a);
      longint unsigned last;
      last = longint'(a) + longint'(nbytes(we));
      if (we == 2'b01 && a[1:0] != 2'b00) return 1'b1;
      if (we == 2'b10 && a[0]) return 1'b1;
      return last > longint'(MB);
   endfunction

   task automatic drive_reqs();
      m0_req_i = pend[0]; m0_we_i = pwe[0]; m0_addr_i = pa[0]; m0_wdata_i = pd[0];
      m1_req_i = pend[1]; m1_we_i = pwe[1]; m1_addr_i = pa[1]; m1_wdata_i = pd[1];
   endtask

   task automatic set_req(input int m, input logic [1:0] we, input logic [31:0] a, input logic [31:0] d);
      pend[m] = 1'b1; pwe[m] = we; pa[m] = a; pd[m] = d;
   endtask

   // One arbitration round: predict winner and response, then compare with the DUT.
   task automatic run_one(output int obs_win);
      int          win;
      int          cyc;
      bit          e;
      logic [31:0] exp_rd;
      logic [31:0] a;
      logic [1:0]  w;
      drive_reqs();
      win = (pend[0] && pend[1]) ? 1 - ref_last : (pend[0] ? 0 : 1);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(m0_gnt_o || m1_gnt_o) && cyc < 6);
      obs_win = m1_gnt_o ? 1 : 0;
      check_eq("gnt0", 32'(m0_gnt_o), 32'(win == 0));
      check_eq("gnt1", 32'(m1_gnt_o), 32'(win == 1));
      w = pwe[win];
      a = pa[win];
      e = model_err(w, a);
      check_eq("mem_we", 32'(mem_we_o), e ? 32'd0 : 32'(w));
      if (!e && w != 2'b00) check_eq("mem_addr", mem_addr_o, a);
      exp_rd = '0;
      if (!e) begin
         for (int i = 0; i < 4; i++) exp_rd[8*i +: 8] = ref_mem[a + 32'(i)];
         for (int i = 0; i < nbytes(w) && w != 2'b00; i++) ref_mem[a + 32'(i)] = pd[win][8*i +: 8];
      end
      ref_last  = win;
      pend[win] = 1'b0;
      if (win == 0) m0_req_i = 1'b0; else m1_req_i = 1'b0;
      @(negedge clk);
      check_eq("rvalid0", 32'(m0_rvalid_o), 32'(win == 0));
      check_eq("rvalid1", 32'(m1_rvalid_o), 32'(win == 1));
      check_eq("rdata0", m0_rdata_o, (win == 0) ? exp_rd : 32'd0);
      check_eq("rdata1", m1_rdata_o, (win == 1) ? exp_rd : 32'd0);
      check_eq("err0", 32'(m0_err_o), 32'(win == 0 && e));
      check_eq("err1", 32'(m1_err_o), 32'(win == 1 && e));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      pend[0] = 1'b0; pend[1] = 1'b0;
      drive_reqs();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      ref_last = 1;
   endtask

   function automatic logic [31:0] rand_addr();
      int unsigned r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
      else if (r == 1) a = 32'($urandom_range(240, 300));
      else             a = 32'($urandom_range(0, 255));
      if (r >= 4) a[1:0] = 2'b00;
      return a;
   endfunction

   initial begin
      int          w;
      int          n0;
      logic [7:0]  b;
      for (int i = 0; i < int'(MB); i++) begin
         b = 8'($urandom);
         mem[i] = b;
         ref_mem[i] = b;
      end
      pwe[0] = 2'b00; pwe[1] = 2'b00; pa[0] = '0; pa[1] = '0; pd[0] = '0; pd[1] = '0;
      do_reset();
      rst = 1'b1;
      @(negedge clk);
      check_eq("rst_gnt", 32'({m0_gnt_o, m1_gnt_o}), 32'd0);
      check_eq("rst_rvalid", 32'({m0_rvalid_o, m1_rvalid_o}), 32'd0);
      check_eq("rst_err", 32'({m0_err_o, m1_err_o}), 32'd0);
      check_eq("rst_rdata0", m0_rdata_o, 32'd0);
      check_eq("rst_rdata1", m1_rdata_o, 32'd0);
      check_eq("rst_mem_we", 32'(mem_we_o), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Word write then readback.
      set_req(0, 2'b01, 32'h10, 32'hDEAD_BEEF); run_one(w);
      set_req(0, 2'b00, 32'h10, 32'h0);         run_one(w);
      check_eq("rd_10", m0_rdata_o, 32'hDEAD_BEEF);

      // Tie from reset alternates m0, m1, m0, m1, m0, m1.
      do_reset();
      n0 = 0;
      for (int k = 0; k < 6; k++) begin
         if (!pend[0] && n0 < 3) set_req(0, 2'b00, 32'(4 * k), 32'h0);
         if (!pend[1]) set_req(1, 2'b00, 32'(4 * k + 64), 32'h0);
         run_one(w);
         if (w == 0) n0++;
         check_eq("rr_order", 32'(w), 32'(k % 2));
      end

      // Misaligned halfword, byte write, word readback.
      set_req(1, 2'b10, 32'h21, 32'h1234_5678); run_one(w);
      set_req(1, 2'b11, 32'h21, 32'h0000_00AB); run_one(w);
      set_req(1, 2'b00, 32'h20, 32'h0);         run_one(w);
      check_eq("byte1", 32'(m1_rdata_o[15:8]), 32'hAB);

      // Bounds at the top of memory and of the address space.
      set_req(0, 2'b00, 32'hFD, 32'h0);         run_one(w);
      set_req(0, 2'b00, 32'hFC, 32'h0);         run_one(w);
      set_req(0, 2'b00, 32'hFFFF_FFFC, 32'h0);  run_one(w);
      check_eq("top_err", 32'(m0_err_o), 32'd1);

      // Write returns old contents.
      set_req(0, 2'b01, 32'h40, 32'hAAAA_AAAA); run_one(w);
      set_req(0, 2'b01, 32'h40, 32'h1122_3344); run_one(w);
      check_eq("old_40", m0_rdata_o, 32'hAAAA_AAAA);
      set_req(0, 2'b00, 32'h40, 32'h0);         run_one(w);

      // Reset during ACCESS of a word write: no write, no response.
      set_req(0, 2'b01, 32'h30, 32'h5555_6666);
      drive_reqs();
      for (int c = 0; c < 6 && !m0_gnt_o; c++) @(negedge clk);
      check_eq("abort_gnt", 32'(m0_gnt_o), 32'd1);
      rst = 1'b1;
      pend[0] = 1'b0;
      m0_req_i = 1'b0;
      #1;
      check_eq("abort_we", 32'(mem_we_o), 32'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check_eq("abort_resp", 32'({m0_rvalid_o, m0_err_o, m1_rvalid_o, m1_err_o}), 32'd0);
      end
      rst = 1'b0;
      ref_last = 1;
      set_req(0, 2'b00, 32'h30, 32'h0);         run_one(w);

      // Random traffic with held losers.
      for (int t = 0; t < 200; t++) begin
         for (int m = 0; m < 2; m++) begin
            if (!pend[m] && ($urandom_range(0, 9) < 6))
               set_req(m, 2'($urandom), rand_addr(), $urandom);
         end
         if (!pend[0] && !pend[1]) set_req(t % 2, 2'($urandom), rand_addr(), $urandom);
         run_one(w);
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
